// File: rtl/beta_pkg.sv
// Shared types for the beta core memory-side blocks.
// Arbiter state and requester identity live here.
package beta_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT_R
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_IF,
        ARB_OWNER_LSU
    } arb_owner_t;

endpackage

// File: rtl/beta_rr_arbiter2.sv
// Two-way requester picker for the memory port arbiter.
// Bit 0 is IF, bit 1 is LSU; purely combinational.
module beta_rr_arbiter2
    import beta_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t rr_last,
    input  logic       fixed_prio,
    output arb_owner_t winner
);

    logic lsu_wins;

    // On a tie LSU wins under fixed priority or when IF was served last.
    always_comb begin
        lsu_wins = req[1] && (!req[0] || fixed_prio ||
                              rr_last == ARB_OWNER_IF);
        winner   = lsu_wins ? ARB_OWNER_LSU : ARB_OWNER_IF;
    end

endmodule

// File: rtl/beta_mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the LSU.
// One memory transaction outstanding; response routed back to its owner.
module beta_mem_port_arbiter
    import beta_pkg::*;
#(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int LsuPriority = 1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   if_req_i,
    input  logic [AddrWidth-1:0]   if_addr_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [DataWidth-1:0]   if_rdata_o,
    input  logic                   lsu_req_i,
    input  logic                   lsu_we_i,
    input  logic [DataWidth/8-1:0] lsu_be_i,
    input  logic [AddrWidth-1:0]   lsu_addr_i,
    input  logic [DataWidth-1:0]   lsu_wdata_i,
    output logic                   lsu_gnt_o,
    output logic                   lsu_rvalid_o,
    output logic [DataWidth-1:0]   lsu_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   arb_busy_o,
    output logic                   arb_err_o
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t rr_last;
    arb_owner_t winner;
    logic       any_req;
    logic       grant;
    logic       resp;
    logic       stray;

    beta_rr_arbiter2 u_pick (
        .req        ({lsu_req_i, if_req_i}),
        .rr_last    (rr_last),
        .fixed_prio (LsuPriority != 0),
        .winner     (winner)
    );

    // Grants are masked while reset is held so nothing leaks out of reset.
    assign any_req = if_req_i | lsu_req_i;
    assign grant   = rstn_i && state == ARB_IDLE && any_req;

    assign if_gnt_o  = grant && winner == ARB_OWNER_IF;
    assign lsu_gnt_o = grant && winner == ARB_OWNER_LSU;

    assign resp  = mem_rvalid_i &&
                   (state == ARB_WAIT_R ||
                    (state == ARB_REQ && mem_gnt_i));
    assign stray = mem_rvalid_i &&
                   (state == ARB_IDLE ||
                    (state == ARB_REQ && !mem_gnt_i));

    assign if_rvalid_o  = resp && owner == ARB_OWNER_IF;
    assign lsu_rvalid_o = resp && owner == ARB_OWNER_LSU;
    assign if_rdata_o   = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;

    assign mem_req_o  = state == ARB_REQ;
    assign arb_busy_o = state != ARB_IDLE;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ARB_IDLE;
            owner       <= ARB_OWNER_IF;
            rr_last     <= ARB_OWNER_IF;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            arb_err_o   <= 1'b0;
        end else begin
            if (stray) begin
                arb_err_o <= 1'b1;
            end
            unique case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        rr_last <= winner;
                        state   <= ARB_REQ;
                        if (winner == ARB_OWNER_LSU) begin
                            mem_we_o    <= lsu_we_i;
                            mem_be_o    <= lsu_be_i;
                            mem_addr_o  <= lsu_addr_i;
                            mem_wdata_o <= lsu_wdata_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_be_o    <= '1;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt_i) begin
                        state <= mem_rvalid_i ? ARB_IDLE : ARB_WAIT_R;
                    end
                end
                ARB_WAIT_R: begin
                    if (mem_rvalid_i) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
